pkt_det_delay_buffer: RTL and testbench
=======================================

PKT_DET_DELAY_BUFFER -- requirements
Module: pkt_det_delay_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning I/Q sample width in two's complement (1 sign bit, 1 integer bit, rest fraction at 8).
REQ-002 SHALL have parameter LAG, default 16, meaning the autocorrelation lag in samples (minimum 1).
REQ-003 SHALL have parameter OUT_DLY, default 48, meaning the extra delay after LAG on the output path (minimum 1); total depth DEPTH = LAG+OUT_DLY.
REQ-004 Clk  in  1  clock; all logic on rising edge.
REQ-005 Rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Clear  in  1  synchronous flush of buffer contents and state.
REQ-007 InputEnable  in  1  input sample valid.
REQ-008 DataInRe, DataInIm  in  DATA_W each  input sample.
REQ-009 Buffer_Enable  out  1  correlator taps valid.
REQ-010 DataARe, DataAIm  out  DATA_W each  current sample.
REQ-011 DataBRe, DataBIm  out  DATA_W each  sample LAG enables earlier.
REQ-012 BValid  out  1  DataB holds real history: at least LAG samples written since reset/Clear.
REQ-013 FrameFinded  in  1  frame detected; output path enable.
REQ-014 OutputEnable  out  1  output sample valid.
REQ-015 DataOutRe, DataOutIm  out  DATA_W each  sample DEPTH enables earlier.
REQ-016 OutStart  out  1  one-cycle pulse on the first OutputEnable of each FrameFinded period.

Function
REQ-017 Stage 0 SHALL register InputEnable and data; data SHALL be forced to 0 when InputEnable is low.
REQ-018 Buffer SHALL be a circular store of DEPTH complex entries, written at wptr when stage-0 enable is high; wptr SHALL wrap from DEPTH-1 to 0.
REQ-019 Tap reads SHALL occur before the same-cycle write: B address = (wptr-LAG) mod DEPTH; Out address = wptr, which holds the oldest entry.
REQ-020 Fill counter SHALL increment per write and saturate at DEPTH.
REQ-021 State machine EMPTY -> FILLING on first write -> FULL when fill reaches DEPTH -> STREAM while FrameFinded is high in FULL; STREAM -> FULL when FrameFinded falls.
REQ-022 Clear SHALL force EMPTY from any state and zero fill count and wptr; Clear SHALL win over a simultaneous write, and that sample SHALL be discarded.
REQ-023 Buffer_Enable, DataA and DataB SHALL register one cycle after a stage-0 enable (latency 2 from InputEnable); when not enabled, all of them SHALL be 0.
REQ-024 DataB SHALL be 0 and BValid SHALL be 0 while fill < LAG; BValid SHALL be registered alongside DataB.
REQ-025 OutputEnable SHALL be 1 one cycle after a stage-0 enable occurs in STREAM (or in FULL with FrameFinded high); otherwise OutputEnable and DataOut SHALL be 0.
REQ-026 FrameFinded asserted in EMPTY or FILLING SHALL produce no output; streaming SHALL start once FULL is reached if FrameFinded is still high.
REQ-027 OutStart SHALL pulse with the first OutputEnable after entering STREAM and re-arm when FrameFinded falls or Clear occurs.
REQ-028 Gaps in InputEnable SHALL freeze wptr, fill count and state; delays SHALL be counted in enables, not cycles.

Reset
REQ-029 Rst_n low SHALL asynchronously clear all outputs to 0, state to EMPTY, and wptr, fill count and stage-0 registers to 0.
REQ-030 Storage array contents SHALL NOT require reset; validity SHALL be governed by the fill count only.
REQ-031 Reset or Clear mid-STREAM SHALL drop OutputEnable on the next edge, and no stale sample SHALL be emitted afterwards.

Structure
REQ-032 Package pkt_det_pkg SHALL hold DATA_W/LAG/OUT_DLY defaults, the state enum and a clog2-based pointer width constant.
REQ-033 One sub-module, cplx_delay_ram (DEPTH x 2*DATA_W, one write port, two asynchronous read ports), SHALL hold the storage.

Verification
REQ-034 Ramp 1,2,3... continuous, defaults: at enable 17, DataA=17, DataB=1, BValid=1; before that DataB=0 and BValid=0.
REQ-035 Ramp with FrameFinded high from the start: first OutputEnable comes with sample 65 (DataOut=1), with OutStart high for exactly that cycle.
REQ-036 Alternating InputEnable 1/0 after FULL: DataB always equals DataA-16 and no Buffer_Enable appears on idle cycles.
REQ-037 Clear together with sample 40: next cycle all outputs are 0; resumed ramp 100,101... gives BValid only at its 17th sample, with DataB=100.
REQ-038 Rst_n pulse mid-STREAM: outputs are 0 immediately; after release, 64 writes are needed before OutputEnable reasserts.
REQ-039 Parameters LAG=4, OUT_DLY=3, DATA_W=12 with values near ±2047: delays of 4 and 7 enables are met and sign is preserved.

Source files
------------

// File: rtl/pkt_det_pkg.sv
// Shared types and defaults for the packet-detector delay buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pkt_det_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int LAG_DEF     = 16;
    localparam int OUT_DLY_DEF = 48;

    // Pointer width for a buffer of the given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PTR_W_DEF = $clog2(LAG_DEF + OUT_DLY_DEF);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_STREAM  = 2'd3
    } state_e;

endpackage

// File: rtl/cplx_delay_ram.sv
// Circular sample store: one synchronous write port, two asynchronous read ports.
// Latency: reads are combinational and return the contents before a same-cycle write.
// Backpressure: none; writes are accepted on every cycle with we high.
// Ports: Clk, we/waddr/wdata write port; raddr_b/rdata_b and raddr_o/rdata_o read ports.
module cplx_delay_ram
    import pkt_det_pkg::*;
#(
    parameter int WIDTH  = 2 * DATA_W_DEF,
    parameter int DEPTH  = LAG_DEF + OUT_DLY_DEF,
    parameter int ADDR_W = PTR_W_DEF
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic [ADDR_W-1:0] raddr_o,
    output logic [WIDTH-1:0]  rdata_o
);

    // No reset: entry validity is tracked by the fill count in the parent.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_b = mem_q[raddr_b];
    assign rdata_o = mem_q[raddr_o];

endmodule

// File: rtl/pkt_det_delay_buffer.sv
// Delay buffer feeding a lag-LAG autocorrelator and a DEPTH-delayed output stream.
// Latency: taps and output register 2 cycles after InputEnable; delays counted in enables.
// Backpressure: none; every enabled sample is consumed, idle cycles freeze all state.
// Ports: Clk, Rst_n (async, active-low), Clear (sync flush), InputEnable/DataIn* in;
//        Buffer_Enable/DataA*/DataB*/BValid taps; FrameFinded in; OutputEnable/DataOut*/OutStart.
module pkt_det_delay_buffer
    import pkt_det_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LAG     = LAG_DEF,
    parameter int OUT_DLY = OUT_DLY_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Clear,
    input  logic              InputEnable,
    input  logic [DATA_W-1:0] DataInRe,
    input  logic [DATA_W-1:0] DataInIm,
    output logic              Buffer_Enable,
    output logic [DATA_W-1:0] DataARe,
    output logic [DATA_W-1:0] DataAIm,
    output logic [DATA_W-1:0] DataBRe,
    output logic [DATA_W-1:0] DataBIm,
    output logic              BValid,
    input  logic              FrameFinded,
    output logic              OutputEnable,
    output logic [DATA_W-1:0] DataOutRe,
    output logic [DATA_W-1:0] DataOutIm,
    output logic              OutStart
);

    localparam int DEPTH   = LAG + OUT_DLY;
    localparam int PTR_W   = ptr_width(DEPTH);
    localparam int FILL_W  = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 2 * DATA_W;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_LAG  = FILL_W'(LAG);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]    PTR_DEPTH = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    B_OFFSET  = (PTR_W + 1)'(DEPTH - LAG);

    state_e              state_q, state_d;
    logic                en0_q, en0_d;
    logic [DATA_W-1:0]   re0_q, re0_d, im0_q, im0_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                armed_q, armed_d;

    logic                buf_en_q, buf_en_d;
    logic [DATA_W-1:0]   a_re_q, a_re_d, a_im_q, a_im_d;
    logic [DATA_W-1:0]   b_re_q, b_re_d, b_im_q, b_im_d;
    logic                bvalid_q, bvalid_d;
    logic                out_en_q, out_en_d;
    logic [DATA_W-1:0]   out_re_q, out_re_d, out_im_q, out_im_d;
    logic                out_start_q, out_start_d;

    logic                wr_en;
    logic                out_path_en;
    logic [PTR_W:0]      b_sum;
    logic [PTR_W-1:0]    b_addr;
    logic [ENTRY_W-1:0]  rd_b, rd_out;

    // Clear discards the sample sitting in stage 0 as well as everything stored.
    assign wr_en = en0_q & ~Clear;

    // (wptr - LAG) mod DEPTH, computed as wptr + (DEPTH - LAG) to stay non-negative.
    assign b_sum  = {1'b0, wptr_q} + B_OFFSET;
    assign b_addr = (b_sum >= PTR_DEPTH) ? PTR_W'(b_sum - PTR_DEPTH) : PTR_W'(b_sum);

    cplx_delay_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .Clk     (Clk),
        .we      (wr_en),
        .waddr   (wptr_q),
        .wdata   ({re0_q, im0_q}),
        .raddr_b (b_addr),
        .rdata_b (rd_b),
        .raddr_o (wptr_q),   // oldest entry once the buffer is full
        .rdata_o (rd_out)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // FULL/STREAM follow FrameFinded directly so a falling FrameFinded during
    // an input gap cannot leave the output path open.
    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:   if (wr_en) state_d = ST_FILLING;
                ST_FILLING: if (wr_en && fill_d == FILL_FULL) state_d = ST_FULL;
                ST_FULL:    if (FrameFinded) state_d = ST_STREAM;
                ST_STREAM:  if (!FrameFinded) state_d = ST_FULL;
                default:    state_d = ST_EMPTY;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_path_en = 1'b0;
        case (state_q)
            ST_STREAM: out_path_en = 1'b1;
            ST_FULL:   out_path_en = FrameFinded;
            default:   out_path_en = 1'b0;
        endcase
    end

    // ---------------- stage 0, pointer and fill ----------------
    always_comb begin
        en0_d  = InputEnable & ~Clear;
        re0_d  = en0_d ? DataInRe : '0;
        im0_d  = en0_d ? DataInIm : '0;
        wptr_d = wptr_q;
        fill_d = fill_q;
        if (Clear) begin
            wptr_d = '0;
            fill_d = '0;
        end else if (wr_en) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // ---------------- tap and output registers ----------------
    always_comb begin
        buf_en_d    = 1'b0;
        a_re_d      = '0;
        a_im_d      = '0;
        b_re_d      = '0;
        b_im_d      = '0;
        bvalid_d    = 1'b0;
        out_en_d    = 1'b0;
        out_re_d    = '0;
        out_im_d    = '0;
        out_start_d = 1'b0;
        if (wr_en) begin
            buf_en_d = 1'b1;
            a_re_d   = re0_q;
            a_im_d   = im0_q;
            // B only carries real history once LAG samples precede this one.
            if (fill_q >= FILL_LAG) begin
                bvalid_d         = 1'b1;
                {b_re_d, b_im_d} = rd_b;
            end
            if (out_path_en) begin
                out_en_d             = 1'b1;
                {out_re_d, out_im_d} = rd_out;
                out_start_d          = armed_q;
            end
        end
        // OutStart re-arms whenever the frame indication drops or the buffer is flushed.
        armed_d = armed_q;
        if (Clear || !FrameFinded) begin
            armed_d = 1'b1;
        end else if (out_en_d) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            en0_q       <= 1'b0;
            re0_q       <= '0;
            im0_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            armed_q     <= 1'b1;
            buf_en_q    <= 1'b0;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            bvalid_q    <= 1'b0;
            out_en_q    <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_start_q <= 1'b0;
        end else begin
            en0_q       <= en0_d;
            re0_q       <= re0_d;
            im0_q       <= im0_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            buf_en_q    <= buf_en_d;
            a_re_q      <= a_re_d;
            a_im_q      <= a_im_d;
            b_re_q      <= b_re_d;
            b_im_q      <= b_im_d;
            bvalid_q    <= bvalid_d;
            out_en_q    <= out_en_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_start_q <= out_start_d;
        end
    end

    assign Buffer_Enable = buf_en_q;
    assign DataARe       = a_re_q;
    assign DataAIm       = a_im_q;
    assign DataBRe       = b_re_q;
    assign DataBIm       = b_im_q;
    assign BValid        = bvalid_q;
    assign OutputEnable  = out_en_q;
    assign DataOutRe     = out_re_q;
    assign DataOutIm     = out_im_q;
    assign OutStart      = out_start_q;

endmodule

// File: tb/tb_pkt_det_delay_buffer.sv
// Bench for pkt_det_delay_buffer: default instance plus a LAG=4/OUT_DLY=3/DATA_W=12 instance.
// Expected tap/output records are queued when a sample is issued; monitors pop on valid.
// Directed spot values (first BValid, first output, OutStart count) are hand-computed.
module tb_pkt_det_delay_buffer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_n;

    // default instance (DATA_W=8, LAG=16, OUT_DLY=48)
    logic       clear0, ie0, ff0;
    logic [7:0] re_in0, im_in0;
    logic       be0, bv0, oe0, os0;
    logic [7:0] a_re0, a_im0, b_re0, b_im0, o_re0, o_im0;

    // small instance (DATA_W=12, LAG=4, OUT_DLY=3)
    logic        clear1, ie1, ff1;
    logic [11:0] re_in1, im_in1;
    logic        be1, bv1, oe1, os1;
    logic [11:0] a_re1, a_im1, b_re1, b_im1, o_re1, o_im1;

    pkt_det_delay_buffer u_dut0 (
        .Clk(Clk), .Rst_n(rst_n), .Clear(clear0), .InputEnable(ie0),
        .DataInRe(re_in0), .DataInIm(im_in0),
        .Buffer_Enable(be0), .DataARe(a_re0), .DataAIm(a_im0),
        .DataBRe(b_re0), .DataBIm(b_im0), .BValid(bv0),
        .FrameFinded(ff0), .OutputEnable(oe0),
        .DataOutRe(o_re0), .DataOutIm(o_im0), .OutStart(os0)
    );

    pkt_det_delay_buffer #(.DATA_W(12), .LAG(4), .OUT_DLY(3)) u_dut1 (
        .Clk(Clk), .Rst_n(rst_n), .Clear(clear1), .InputEnable(ie1),
        .DataInRe(re_in1), .DataInIm(im_in1),
        .Buffer_Enable(be1), .DataARe(a_re1), .DataAIm(a_im1),
        .DataBRe(b_re1), .DataBIm(b_im1), .BValid(bv1),
        .FrameFinded(ff1), .OutputEnable(oe1),
        .DataOutRe(o_re1), .DataOutIm(o_im1), .OutStart(os1)
    );

    typedef struct packed {
        logic [11:0] a_re, a_im, b_re, b_im;
        logic        bv;
    } tap_t;

    typedef struct packed {
        logic [11:0] re, im;
        logic        st;
    } out_t;

    tap_t tapq0[$], tapq1[$];
    out_t outq0[$], outq1[$];

    // history of every sample written since reset/Clear, in order
    logic [23:0] hist [2][1024];
    int          hcnt [2];
    logic        pend_vld [2];
    logic [11:0] pend_re [2], pend_im [2];
    logic        armed [2];

    int tests = 0;
    int fails = 0;

    // spot captures, -1 = not seen yet
    int fb_a [2], fb_b [2], fo_a [2], fo_v [2], os_cnt [2];

    logic [11:0] s1 [12];

    function automatic int lag_of(input int id);
        return (id == 0) ? 16 : 4;
    endfunction

    function automatic int depth_of(input int id);
        return (id == 0) ? 64 : 7;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int id);
        hcnt[id]     = 0;
        pend_vld[id] = 1'b0;
        armed[id]    = 1'b1;
    endtask

    task automatic spot_reset(input int id);
        fb_a[id] = -1;
        fb_b[id] = -1;
        fo_a[id] = -1;
        fo_v[id] = -1;
    endtask

    // Sample pending in stage 0 reaches the RAM and the output registers.
    task automatic commit(input int id);
        tap_t t;
        out_t o;
        logic ffv;
        int   n, l, d;
        n   = hcnt[id];
        l   = lag_of(id);
        d   = depth_of(id);
        ffv = (id == 0) ? ff0 : ff1;
        t   = '0;
        t.a_re = pend_re[id];
        t.a_im = pend_im[id];
        if (n >= l) begin
            t.bv   = 1'b1;
            t.b_re = hist[id][n - l][23:12];
            t.b_im = hist[id][n - l][11:0];
        end
        if (n >= d && ffv) begin
            o.re = hist[id][n - d][23:12];
            o.im = hist[id][n - d][11:0];
            o.st = armed[id];
            armed[id] = 1'b0;
            if (id == 0) outq0.push_back(o); else outq1.push_back(o);
        end
        hist[id][n] = {pend_re[id], pend_im[id]};
        hcnt[id]    = n + 1;
        if (id == 0) tapq0.push_back(t); else tapq1.push_back(t);
    endtask

    // One clock of stimulus for instance id; returns 1 time unit after the edge.
    task automatic cyc(input int id, input logic en, input logic [11:0] re,
                       input logic [11:0] im, input logic clr);
        logic ffv;
        if (pend_vld[id] && !clr) commit(id);
        if (clr) begin
            hcnt[id]  = 0;
            armed[id] = 1'b1;
        end
        ffv = (id == 0) ? ff0 : ff1;
        if (!ffv) armed[id] = 1'b1;
        pend_vld[id] = en && !clr;
        pend_re[id]  = re;
        pend_im[id]  = im;
        if (id == 0) begin
            ie0 = en; re_in0 = re[7:0]; im_in0 = im[7:0]; clear0 = clr;
        end else begin
            ie1 = en; re_in1 = re; im_in1 = im; clear1 = clr;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int id, input int n);
        for (int i = 0; i < n; i++) cyc(id, 1'b0, 12'h0, 12'h0, 1'b0);
    endtask

    task automatic ramp0(input int first, input int last);
        for (int v = first; v <= last; v++)
            cyc(0, 1'b1, 12'(v), 12'(v ^ 8'h5A), 1'b0);
    endtask

    task automatic chk_zero0(input string name);
        chk(name, {be0, a_re0, a_im0, b_re0, b_im0, bv0, oe0, o_re0, o_im0, os0}, 64'h0);
    endtask

    task automatic chk_zero1(input string name);
        chk(name, {be1, a_re1, a_im1, b_re1, b_im1, bv1}, 64'h0);
        chk({name, "_out"}, {oe1, o_re1, o_im1, os1}, 64'h0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge Clk) begin : mon0
        tap_t t;
        out_t o;
        if (be0) begin
            if (tapq0.size() == 0) chk("tap0_unexpected", 64'(be0), 64'h0);
            else begin
                t = tapq0.pop_front();
                chk("tap0", {4'h0, a_re0, 4'h0, a_im0, 4'h0, b_re0, 4'h0, b_im0, bv0}, 64'(t));
            end
            if (bv0 && fb_a[0] < 0) begin fb_a[0] = int'(a_re0); fb_b[0] = int'(b_re0); end
        end else begin
            chk("tap0_idle_zero", {a_re0, a_im0, b_re0, b_im0, bv0}, 64'h0);
        end
        if (oe0) begin
            if (outq0.size() == 0) chk("out0_unexpected", 64'(oe0), 64'h0);
            else begin
                o = outq0.pop_front();
                chk("out0", {4'h0, o_re0, 4'h0, o_im0, os0}, 64'(o));
            end
            if (fo_a[0] < 0) begin fo_a[0] = int'(a_re0); fo_v[0] = int'(o_re0); end
        end else begin
            chk("out0_idle_zero", {o_re0, o_im0, os0}, 64'h0);
        end
        if (os0) os_cnt[0]++;
    end

    always @(negedge Clk) begin : mon1
        tap_t t;
        out_t o;
        if (be1) begin
            if (tapq1.size() == 0) chk("tap1_unexpected", 64'(be1), 64'h0);
            else begin
                t = tapq1.pop_front();
                chk("tap1", {a_re1, a_im1, b_re1, b_im1, bv1}, 64'(t));
            end
            if (bv1 && fb_a[1] < 0) begin fb_a[1] = int'(a_re1); fb_b[1] = int'(b_re1); end
        end else begin
            chk("tap1_idle_zero", {a_re1, a_im1, b_re1, b_im1, bv1}, 64'h0);
        end
        if (oe1) begin
            if (outq1.size() == 0) chk("out1_unexpected", 64'(oe1), 64'h0);
            else begin
                o = outq1.pop_front();
                chk("out1", {o_re1, o_im1, os1}, 64'(o));
            end
            if (fo_a[1] < 0) begin fo_a[1] = int'(a_re1); fo_v[1] = int'(o_re1); end
        end else begin
            chk("out1_idle_zero", {o_re1, o_im1, os1}, 64'h0);
        end
        if (os1) os_cnt[1]++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        s1 = '{12'h7FF, 12'h800, 12'h7FE, 12'h801, 12'h7FD, 12'h802,
               12'h001, 12'hFFF, 12'h7D0, 12'h830, 12'h7FC, 12'h803};
        clear0 = 0; ie0 = 0; ff0 = 1; re_in0 = 0; im_in0 = 0;
        clear1 = 0; ie1 = 0; ff1 = 1; re_in1 = 0; im_in1 = 0;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            spot_reset(i);
            os_cnt[i] = 0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk_zero0("reset0_outputs");
        chk_zero1("reset1_outputs");
        rst_n = 1'b1;

        // Continuous ramp, FrameFinded high throughout.
        ramp0(1, 80);
        idle(0, 2);
        chk("ramp_first_bvalid_dataA", 64'(fb_a[0]), 64'd17);
        chk("ramp_first_bvalid_dataB", 64'(fb_b[0]), 64'd1);
        chk("ramp_first_out_dataA", 64'(fo_a[0]), 64'd65);
        chk("ramp_first_out_value", 64'(fo_v[0]), 64'd1);
        chk("ramp_outstart_count", 64'(os_cnt[0]), 64'd1);

        // Alternating enables on a full buffer.
        for (int v = 81; v <= 100; v++) begin
            cyc(0, 1'b1, 12'(v), 12'(v ^ 8'h5A), 1'b0);
            cyc(0, 1'b0, 12'h0, 12'h0, 1'b0);
        end
        // Frame indication drops, samples flow with no output, then returns.
        ff0 = 1'b0;
        idle(0, 2);
        ramp0(101, 104);
        idle(0, 2);
        ff0 = 1'b1;
        idle(0, 2);
        spot_reset(0);
        ramp0(105, 108);
        idle(0, 2);
        chk("rearm_outstart_count", 64'(os_cnt[0]), 64'd2);
        chk("rearm_first_out_dataA", 64'(fo_a[0]), 64'd105);
        chk("rearm_first_out_value", 64'(fo_v[0]), 64'd41);

        // Clear arriving together with sample 40.
        for (int v = 30; v <= 40; v++)
            cyc(0, 1'b1, 12'(v), 12'(v ^ 8'h5A), (v == 40) ? 1'b1 : 1'b0);
        chk_zero0("after_clear_outputs");
        spot_reset(0);
        ramp0(100, 180);
        chk("clear_first_bvalid_dataA", 64'(fb_a[0]), 64'd116);
        chk("clear_first_bvalid_dataB", 64'(fb_b[0]), 64'd100);
        chk("clear_first_out_dataA", 64'(fo_a[0]), 64'd164);
        chk("clear_first_out_value", 64'(fo_v[0]), 64'd100);

        // Asynchronous reset while streaming.
        @(negedge Clk);
        #1;
        chk("pre_reset_streaming", 64'(oe0), 64'd1);
        rst_n = 1'b0;
        ie0   = 1'b0;
        #1;
        chk_zero0("async_reset_outputs");
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge Clk);
        #1;
        rst_n = 1'b1;
        spot_reset(0);
        ramp0(1, 70);
        idle(0, 2);
        chk("post_reset_first_out_dataA", 64'(fo_a[0]), 64'd65);
        chk("post_reset_first_out_value", 64'(fo_v[0]), 64'd1);
        chk("total_outstart_count0", 64'(os_cnt[0]), 64'd4);

        // Small instance: short delays, full-scale signed values.
        for (int i = 0; i < 12; i++) cyc(1, 1'b1, s1[i], ~s1[i], 1'b0);
        idle(1, 2);
        chk("small_first_bvalid_dataA", 64'(fb_a[1]), 64'h7FD);
        chk("small_first_bvalid_dataB", 64'(fb_b[1]), 64'h7FF);
        chk("small_first_out_dataA", 64'(fo_a[1]), 64'hFFF);
        chk("small_first_out_value", 64'(fo_v[1]), 64'h7FF);
        chk("small_outstart_count", 64'(os_cnt[1]), 64'd1);

        idle(0, 3);
        idle(1, 3);
        chk("drain0_pending", 64'(tapq0.size() + outq0.size()), 64'd0);
        chk("drain1_pending", 64'(tapq1.size() + outq1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
